// File: rtl/uart_rx_fsm_pkg.sv
// Shared constants for the UART receiver: baud divisors at 12 MHz and FSM state encoding.
package uart_rx_fsm_pkg;

  localparam int unsigned B115200 = 104;
  localparam int unsigned B57600  = 208;
  localparam int unsigned B38400  = 313;
  localparam int unsigned B19200  = 625;
  localparam int unsigned B9600   = 1250;
  localparam int unsigned B4800   = 2500;
  localparam int unsigned B2400   = 5000;
  localparam int unsigned B1200   = 10000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } state_e;

endpackage

// File: rtl/uart_rx_fsm_baudgen_rx.sv
// Loadable bit timer: loads HALF-1 or BAUD-1 on demand, counts down and flags tick at zero.
module uart_rx_fsm_baudgen_rx
  import uart_rx_fsm_pkg::*;
#(
  parameter int unsigned BAUD = B9600,
  parameter int unsigned HALF = BAUD / 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_load,
  input  logic i_half,
  output logic o_tick
);

  localparam int unsigned W = $clog2(BAUD);
  localparam logic [W-1:0] LdBaud = W'(BAUD - 1);
  localparam logic [W-1:0] LdHalf = W'(HALF - 1);

  logic [W-1:0] r_cnt;

  // Holds at zero once expired so an unloaded timer never wraps.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_half ? LdHalf : LdBaud;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver with centre sampling, valid/ack handshake, framing-error and overrun flags.
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
#(
  parameter int unsigned BAUD = B9600,
  parameter int unsigned HALF = BAUD / 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ack,
  output logic       o_ferr,
  output logic       o_ovr,
  output logic       o_busy
);

  state_e r_state, w_state_d;

  logic       r_sync1, r_rs, r_rx_prev;
  logic [1:0] r_flush;
  logic       r_armed;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shreg;
  logic [7:0] r_data;
  logic       r_valid, r_ferr, r_ovr;

  logic w_tick, w_load, w_half, w_fall, w_sample, w_done, w_bad;

  uart_rx_fsm_baudgen_rx #(
    .BAUD(BAUD),
    .HALF(HALF)
  ) u_timer (
    .clk   (clk),
    .rstn  (rstn),
    .i_load(w_load),
    .i_half(w_half),
    .o_tick(w_tick)
  );

  // Only arm once rs carries a real line sample of 1, so a line held low through reset is ignored.
  assign w_fall = r_armed & r_rx_prev & ~r_rs;

  always_comb begin
    w_state_d = r_state;
    w_load    = 1'b0;
    w_half    = 1'b0;
    w_sample  = 1'b0;
    w_done    = 1'b0;
    w_bad     = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_fall) begin
          w_state_d = StStart;
          w_load    = 1'b1;
          w_half    = 1'b1;
        end
      end
      StStart: begin
        if (w_tick) begin
          if (!r_rs) begin
            w_state_d = StData;
            w_load    = 1'b1;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      StData: begin
        if (w_tick) begin
          w_sample = 1'b1;
          w_load   = 1'b1;
          if (r_bitcnt == 3'd7) begin
            w_state_d = StStop;
          end
        end
      end
      StStop: begin
        if (w_tick) begin
          w_state_d = StIdle;
          w_done    = r_rs;
          w_bad     = ~r_rs;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync1   <= 1'b1;
      r_rs      <= 1'b1;
      r_rx_prev <= 1'b1;
      r_flush   <= 2'b00;
      r_armed   <= 1'b0;
      r_bitcnt  <= 3'd0;
      r_shreg   <= 8'h00;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_sync1   <= i_rx;
      r_rs      <= r_sync1;
      r_rx_prev <= r_rs;
      r_flush   <= {r_flush[0], 1'b1};
      if (r_flush[1] && r_rs) begin
        r_armed <= 1'b1;
      end

      if (r_state == StStart && w_load) begin
        r_bitcnt <= 3'd0;
      end else if (w_sample) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end
      if (w_sample) begin
        r_shreg <= {r_rs, r_shreg[7:1]};
      end

      r_ferr <= w_bad;

      if (w_done) begin
        r_data  <= r_shreg;
        r_valid <= 1'b1;
      end else if (i_ack) begin
        r_valid <= 1'b0;
      end

      // A completion racing an ack is a clean handoff, not an overrun.
      if (w_done && r_valid && !i_ack) begin
        r_ovr <= 1'b1;
      end else if (i_ack) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_ferr  = r_ferr;
  assign o_ovr   = r_ovr;
  assign o_busy  = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm at BAUD=16: expected bytes are queued as frames are sent.
module tb_uart_rx_fsm;

  localparam int unsigned BAUD = 16;
  localparam int unsigned HALF = 8;

  typedef struct packed {
    logic [7:0] data;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid, ferr, ovr, busy;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned n_ferr = 0;
  exp_t        sb[$];

  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_busy = 1'b0;

  uart_rx_fsm #(
    .BAUD(BAUD),
    .HALF(HALF)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .i_rx   (rx),
    .o_data (data),
    .o_valid(valid),
    .i_ack  (ack),
    .o_ferr (ferr),
    .o_ovr  (ovr),
    .o_busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop;
    repeat (BAUD) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_valid(input int unsigned limit);
    int unsigned t = 0;
    while (!valid && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (!valid) check_eq("valid_timeout", {31'd0, valid}, 32'd1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovr  = o;
    sb.push_back(e);
  endtask

  // Each new byte shows up as a valid rise or a data change while valid stays high.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rstn) begin
      if (valid && (!prev_valid || data != prev_data)) begin
        check_eq("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("sb_data", {24'd0, data}, {24'd0, e.data});
          check_eq("sb_ovr", {31'd0, ovr}, {31'd0, e.ovr});
        end
      end
      if (ferr) begin
        n_ferr <= n_ferr + 1;
        check_eq("ferr_busy", {30'd0, prev_busy, busy}, 32'b10);
      end
    end
    prev_valid <= valid;
    prev_data  <= data;
    prev_busy  <= busy;
  end

  initial begin
    int unsigned cnt;

    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_out", {20'd0, data, valid, ferr, ovr, busy}, 32'd0);
    repeat (10) @(negedge clk);

    // Single byte, held without ack for 100 cycles.
    push_exp(8'h41, 1'b0);
    send_byte(8'h41, 1'b1);
    wait_valid(50);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (!valid) cnt++;
    end
    check_eq("valid_hold", cnt, 0);
    check_eq("b1_data", {24'd0, data}, 32'h41);
    pulse_ack();
    check_eq("ack_clear", {31'd0, valid}, 32'd0);
    check_eq("b1_flags", {30'd0, ferr, ovr}, 32'd0);

    // Framing error.
    send_byte(8'h55, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("ferr_count", n_ferr, 1);
    check_eq("ferr_valid", {31'd0, valid}, 32'd0);
    check_eq("ferr_data", {24'd0, data}, 32'h41);

    // Start glitch.
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      rx = (i < 6) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) cnt++;
    end
    check_eq("glitch_busy", cnt, 8);
    check_eq("glitch_flags", {29'd0, valid, ferr, ovr}, 32'd0);
    check_eq("glitch_ferr", n_ferr, 1);

    // Back-to-back with ack after the first byte.
    push_exp(8'hA5, 1'b0);
    push_exp(8'h3C, 1'b0);
    fork
      begin
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
      end
      begin
        wait_valid(400);
        pulse_ack();
      end
    join
    repeat (20) @(negedge clk);
    check_eq("b2b_ack", {22'd0, data, valid, ovr}, {22'd0, 8'h3C, 1'b1, 1'b0});
    pulse_ack();
    check_eq("b2b_ack_clr", {31'd0, valid}, 32'd0);

    // Back-to-back without ack: overrun.
    push_exp(8'hA5, 1'b0);
    push_exp(8'h3C, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    check_eq("ovr_state", {22'd0, data, valid, ovr}, {22'd0, 8'h3C, 1'b1, 1'b1});
    pulse_ack();
    check_eq("ovr_clear", {30'd0, valid, ovr}, 32'd0);

    // Reset mid-frame after four data bits of 0xFF.
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BAUD) @(negedge clk);
    check_eq("midframe_busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("midrst_out", {20'd0, data, valid, ferr, ovr, busy}, 32'd0);
    repeat (10) @(negedge clk);
    push_exp(8'h81, 1'b0);
    send_byte(8'h81, 1'b1);
    wait_valid(50);
    check_eq("after_rst", {24'd0, data}, 32'h81);
    pulse_ack();

    // Line held low through reset.
    rx = 1'b0;
    rstn = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check_eq("low_rst_busy", cnt, 0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("low_rst_idle", {29'd0, valid, ferr, busy}, 32'd0);
    push_exp(8'h7E, 1'b0);
    send_byte(8'h7E, 1'b1);
    wait_valid(50);
    check_eq("low_rst_data", {24'd0, data}, 32'h7E);
    pulse_ack();
    repeat (5) @(negedge clk);

    check_eq("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
